// File: rtl/seven_seg_scan_driver.sv
// Purpose : time-multiplexed hex driver for a NUM_DIGITS common-anode 7-segment display.
// Latency : a load is displayed from the next ON slot; outputs are registered and change only on state entry.
// Backpr. : none; load is always accepted and never perturbs scan timing.
//
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   hex_in        NUM_DIGITS packed nibbles, digit 0 = hex_in[3:0] (rightmost)
//   load          capture hex_in into the shadow register on this edge
//   digit_en      per-digit enable, sampled when a digit's ON slot starts
//   seg           {a..g}, active low; anode: active-low digit select
//   digit_idx     index of the digit owning the current scan slot
// Optional feature: define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 16,
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int CMAX  = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t                       state_q;
  state_t                       state_d;
  logic [CNT_W-1:0]             cnt_q;
  logic [NUM_DIGITS-1:0][3:0]   shadow_q;
  logic                         slot_done;
  logic                         digit_lit;
  logic [3:0]                   cur_nib;
  logic [NUM_DIGITS-1:0]        cur_onehot;
  logic [6:0]                   seg_d;
  logic [NUM_DIGITS-1:0]        anode_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Last cycle of the current state's dwell time.
  assign slot_done  = (state_q == ST_BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == ON_LAST);
  assign cur_nib    = shadow_q[digit_idx];
  assign cur_onehot = NUM_DIGITS'(1) << digit_idx;

`ifdef SEVEN_SEG_LZB_EN
  // lzb_dark[i] is set when digit i and every digit above it hold zero.
  // Digit 0 is never blanked so a zero value still shows a single "0".
  logic [NUM_DIGITS-1:0] lzb_dark;
  logic                  above_zero;

  always_comb begin
    above_zero = 1'b1;
    lzb_dark   = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      above_zero  = above_zero & (shadow_q[i] == 4'h0);
      lzb_dark[i] = above_zero;
    end
  end

  assign digit_lit = digit_en[digit_idx] & ~lzb_dark[digit_idx];
`else
  assign digit_lit = digit_en[digit_idx];
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (slot_done) begin
      state_d = (state_q == ST_BLANK) ? ST_ON : ST_BLANK;
    end
  end

  // Output logic: next values for the registered pins. The ON image is
  // computed once at BLANK->ON and then held for the whole slot, so shadow
  // or enable changes mid-slot cannot glitch the lit digit.
  always_comb begin
    seg_d   = 7'h7F;
    anode_d = '1;
    if (state_q == ST_BLANK && slot_done) begin
      if (digit_lit) begin
        seg_d   = seg_decode(cur_nib);
        anode_d = ~cur_onehot;
      end
    end else if (state_q == ST_ON && !slot_done) begin
      seg_d   = seg;
      anode_d = anode;
    end
  end

  // Dwell counter, scan index, shadow register and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      digit_idx <= '0;
      shadow_q  <= '0;
      seg       <= 7'h7F;
      anode     <= '1;
    end else begin
      cnt_q <= slot_done ? '0 : cnt_q + 1'b1;
      if (state_q == ST_ON && slot_done) begin
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end
      if (load) begin
        shadow_q <= hex_in;
      end
      seg   <= seg_d;
      anode <= anode_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (4 digits, 8 lit cycles, 2 blank cycles).
// The stimulus process predicts the post-edge pin image from a timeline model
// (cycle number since reset release -> slot/phase) and queues it; a monitor
// process pops and compares one image after every rising edge.
module tb_seven_seg_scan_driver;

  localparam int ND   = 4;
  localparam int RC   = 8;
  localparam int BC   = 2;
  localparam int SLOT = RC + BC;
  localparam int SCAN = ND * SLOT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] hex_in;
  logic        load;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_CYCLES (RC),
    .BLANK_CYCLES   (BC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hex_in    (hex_in),
    .load      (load),
    .digit_en  (digit_en),
    .seg       (seg),
    .anode     (anode),
    .digit_idx (digit_idx)
  );

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic [1:0] idx;
  } obs_t;

  localparam obs_t DARK = '{anode: 4'hF, seg: 7'h7F, idx: 2'd0};

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  obs_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          lzb;

  // Reference model state
  int          k;        // rising edges since reset release, -1 while in reset
  logic [15:0] sh;       // what the shadow register should hold
  logic [15:0] lat_sh;   // shadow as seen when the current slot started
  logic [3:0]  lat_en;   // digit_en as seen when the current slot started

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got anode=%b seg=%b idx=%0d, expected anode=%b seg=%b idx=%0d",
               name, $time, act.anode, act.seg, act.idx, exp.anode, exp.seg, exp.idx);
    end
  endtask

  function automatic bit lit(input int d);
    bit l;
    l = lat_en[d];
    if (lzb && d > 0 && (lat_sh >> (4 * d)) == 16'h0) l = 1'b0;
    return l;
  endfunction

  // Predict the pin image after the coming rising edge from the current inputs.
  task automatic step();
    obs_t e;
    int   p;
    int   d;
    e = DARK;
    if (!reset_n) begin
      k  = -1;
      sh = 16'h0;
    end else begin
      k++;
      p = k % SLOT;
      d = (k / SLOT) % ND;
      if (p == BC - 1) begin
        lat_sh = sh;
        lat_en = digit_en;
      end
      if (load) sh = hex_in;
      e.idx = 2'(((k + 1) / SLOT) % ND);
      if (p >= BC - 1 && p <= BC + RC - 2 && lit(d)) begin
        e.anode = ~(4'(1) << d);
        e.seg   = seg_tab[lat_sh[4*d +: 4]];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    step();
    @(negedge clk);
  endtask

  task automatic load_word(input logic [15:0] v);
    hex_in = v;
    load   = 1'b1;
    cyc();
    load   = 1'b0;
    hex_in = 16'($urandom);
  endtask

  // Monitor: one comparison per rising edge whenever an image is pending.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scan", {anode, seg, digit_idx}, e);
      end
    end
  end

  initial begin
`ifdef SEVEN_SEG_LZB_EN
    lzb = 1'b1;
`else
    lzb = 1'b0;
`endif
    reset_n  = 1'b0;
    load     = 1'b0;
    hex_in   = 16'h0;
    digit_en = 4'hF;
    k        = -1;
    sh       = 16'h0;
    lat_sh   = 16'h0;
    lat_en   = 4'h0;
    @(negedge clk);

    // Reset held, then released with an all-zero shadow.
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (SCAN + 10) cyc();

    // Full scan of 12AF.
    load_word(16'h12AF);
    repeat (SCAN + 5) cyc();

    // Load 3333 on lit cycle 3 of digit 1's slot.
    while ((k + 1) % SCAN != SLOT + BC - 1 + 2) cyc();
    load_word(16'h3333);
    repeat (SCAN) cyc();

    // Alternate digits disabled.
    digit_en = 4'b0101;
    repeat (SCAN + 5) cyc();
    digit_en = 4'hF;

    // Leading zeros, then an all-zero value.
    load_word(16'h0070);
    repeat (SCAN + 5) cyc();
    load_word(16'h0000);
    repeat (SCAN + 5) cyc();

    // Load exactly on a BLANK->ON edge.
    while ((k + 1) % SLOT != BC - 1) cyc();
    load_word(16'hC0DE);
    repeat (SCAN + 5) cyc();

    // Asynchronous reset in the middle of digit 2's lit slot.
    while (k % SCAN != 2 * SLOT + BC + 2) cyc();
    reset_n = 1'b0;
    #1;
    check("async_reset", {anode, seg, digit_idx}, DARK);
    cyc();
    cyc();
    reset_n = 1'b1;
    repeat (SCAN + 10) cyc();

    // Randomised loads, values and enables.
    repeat (500) begin
      if ($urandom_range(0, 5) == 0) begin
        load = 1'b1;
        case ($urandom_range(0, 3))
          0:       hex_in = 16'h0000;
          1:       hex_in = 16'($urandom) & 16'h00FF;
          default: hex_in = 16'($urandom);
        endcase
      end else begin
        load   = 1'b0;
        hex_in = 16'($urandom);
      end
      if ($urandom_range(0, 31) == 0) digit_en = 4'($urandom);
      cyc();
    end
    load = 1'b0;

    // Every queued image must have been consumed by the monitor.
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: %0d images left unchecked, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
